// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack pointer sequencer.
//   OP_*    : operation codes presented on op_code
//   SP_STEP : byte distance between stacked 16-bit words
//   state_e : sequencer states
package stack_seq_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam int SP_STEP = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_MEM  = 3'd2,
    ST_INC  = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/stack_seq.sv
// stack_seq: sequencer for the 16-bit stack pointer register.
// Takes PUSH / POP / PEEK / LOAD_SP requests from the control unit, pulses the
// SP register strobes and runs the data-memory handshake. The stack is
// full-descending with pre-decrement; SP itself lives outside this block and
// supplies the memory address over the address bus while sp_read_abus is high.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   op_valid/op_code/op_data, op_ready : operation request channel
//   done, rdata           : completion pulse, POP/PEEK result (held until next done)
//   sp_din, sp_read_abus, sp_read_dbus, sp_write, sp_inc, sp_dec : SP register controls
//   mem_req, mem_we, mem_wdata, mem_rdata, mem_ack : data memory handshake
//   depth                 : words on the stack (guard build only, else 0)
//   err_overflow, err_underflow : one-cycle error pulses (guard build only)
//
// Build option: define STACK_SEQ_GUARD_EN to enable the depth counter and the
// overflow/underflow guard. Without it depth and err_* are tied to 0.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH_MAX = 256,
  parameter int OP_W      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               op_valid,
  input  logic [OP_W-1:0]                    op_code,
  input  logic [DATA_W-1:0]                  op_data,
  output logic                               op_ready,
  output logic                               done,
  output logic [DATA_W-1:0]                  rdata,
  output logic [15:0]                        sp_din,
  output logic                               sp_read_abus,
  output logic                               sp_read_dbus,
  output logic                               sp_write,
  output logic                               sp_inc,
  output logic                               sp_dec,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_ack,
  output logic [$clog2(DEPTH_MAX+1)-1:0]     depth,
  output logic                               err_overflow,
  output logic                               err_underflow
);

  localparam int DEPTH_W = $clog2(DEPTH_MAX+1);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                accept;
  logic                ovf_hit;
  logic                unf_hit;

  assign accept = op_valid && (state_q == ST_IDLE);

`ifdef STACK_SEQ_GUARD_EN
  logic [DEPTH_W-1:0]  depth_q;
  logic                ovf_q;
  logic                unf_q;

  // Guard decisions are taken on the incoming request, before it is latched.
  assign ovf_hit = (op_code == OP_PUSH) && (depth_q == DEPTH_W'(DEPTH_MAX));
  assign unf_hit = ((op_code == OP_POP) || (op_code == OP_PEEK)) && (depth_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (accept) begin
        ovf_q <= ovf_hit;
        unf_q <= unf_hit;
      end
      // Depth moves on the edge entering DONE so it is current during done.
      if (state_q == ST_MEM && mem_ack && op_q == OP_PUSH) begin
        depth_q <= depth_q + DEPTH_W'(1);
      end else if (state_q == ST_INC) begin
        depth_q <= depth_q - DEPTH_W'(1);
      end else if (state_q == ST_LOAD) begin
        depth_q <= '0;
      end
    end
  end

  assign depth         = depth_q;
  assign err_overflow  = (state_q == ST_DONE) && ovf_q;
  assign err_underflow = (state_q == ST_DONE) && unf_q;
`else
  assign ovf_hit       = 1'b0;
  assign unf_hit       = 1'b0;
  assign depth         = '0;
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (ovf_hit || unf_hit) begin
            state_d = ST_DONE;
          end else begin
            case (op_code)
              OP_PUSH: state_d = ST_DEC;
              OP_LOAD: state_d = ST_LOAD;
              default: state_d = ST_MEM;
            endcase
          end
        end
      end
      ST_DEC:  state_d = ST_MEM;
      ST_MEM: begin
        if (mem_ack) begin
          state_d = (op_q == OP_POP) ? ST_INC : ST_DONE;
        end
      end
      ST_INC:  state_d = ST_DONE;
      ST_LOAD: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= op_code;
      end
      // rdata only changes on the edge into DONE, so it stays stable from
      // one done to the next. PEEK leaves MEM straight for DONE and takes the
      // bus value; POP passes through INC and uses the buffered word.
      if (state_q == ST_MEM && mem_ack && op_q == OP_PEEK) begin
        rdata_q <= mem_rdata;
      end else if (state_q == ST_INC) begin
        rdata_q <= rbuf_q;
      end
    end
  end

  // Data registers (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= op_data;
    end
    if (state_q == ST_MEM && mem_ack) begin
      rbuf_q <= mem_rdata;
    end
  end

  // Moore outputs
  assign op_ready     = (state_q == ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign sp_dec       = (state_q == ST_DEC);
  assign sp_inc       = (state_q == ST_INC);
  assign sp_write     = (state_q == ST_LOAD);
  assign mem_req      = (state_q == ST_MEM);
  assign sp_read_abus = (state_q == ST_MEM);
  assign sp_read_dbus = 1'b0;
  assign mem_we       = (state_q == ST_MEM) && (op_q == OP_PUSH);
  assign mem_wdata    = data_q;
  assign sp_din       = 16'(data_q);
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_stack_seq.sv
// Testbench for stack_seq: directed scenarios with literal expectations,
// followed by randomized operations checked every cycle against a
// transaction-level model (a queue of stacked values plus an expected
// per-cycle strobe schedule derived from the operation rules). The bench also
// plays the SP register and the data memory.
module tb_stack_seq;
  import stack_seq_pkg::*;

`ifdef STACK_SEQ_GUARD_EN
  localparam int TB_DMAX = 2;
  localparam bit GUARD   = 1'b1;
`else
  localparam int TB_DMAX = 256;
  localparam bit GUARD   = 1'b0;
`endif
  localparam int DW = $clog2(TB_DMAX+1);

  // strobe vector bit positions
  localparam logic [10:0] B_READY = 11'h400;
  localparam logic [10:0] B_DONE  = 11'h200;
  localparam logic [10:0] B_ABUS  = 11'h100;
  localparam logic [10:0] B_WRITE = 11'h040;
  localparam logic [10:0] B_INC   = 11'h020;
  localparam logic [10:0] B_DEC   = 11'h010;
  localparam logic [10:0] B_REQ   = 11'h008;
  localparam logic [10:0] B_WE    = 11'h004;
  localparam logic [10:0] B_OVF   = 11'h002;
  localparam logic [10:0] B_UNF   = 11'h001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic [15:0]   op_data = 16'h0;
  logic          op_ready, done;
  logic [15:0]   rdata, sp_din, mem_wdata;
  logic          sp_read_abus, sp_read_dbus, sp_write, sp_inc, sp_dec;
  logic          mem_req, mem_we;
  logic [15:0]   mem_rdata = 16'h0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] depth;
  logic          err_overflow, err_underflow;

  stack_seq #(.DATA_W(16), .DEPTH_MAX(TB_DMAX), .OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_code(op_code), .op_data(op_data), .op_ready(op_ready),
    .done(done), .rdata(rdata),
    .sp_din(sp_din), .sp_read_abus(sp_read_abus), .sp_read_dbus(sp_read_dbus),
    .sp_write(sp_write), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .depth(depth), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- environment: SP register and memory ----------------
  logic [15:0] env_sp = 16'h0;
  logic [15:0] mem_m [0:65535];

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem_m[env_sp] <= mem_wdata;
    if (sp_write)      env_sp <= sp_din;
    else if (sp_inc)   env_sp <= env_sp + 16'(SP_STEP);
    else if (sp_dec)   env_sp <= env_sp - 16'(SP_STEP);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [10:0] vec;
    logic        chk_wd;
    logic [15:0] wd;
    logic        chk_din;
    logic [15:0] din;
    logic        is_done;
    int          depth_after;
    logic [15:0] rdata_after;
  } exp_t;

  exp_t        sched[$];
  logic [15:0] vals[$];       // values currently on the stack, top at the back
  int          cur_depth = 0;
  logic [15:0] cur_rdata = 16'h0;
  int          plan_wait = 1; // MEM cycles the responder waits before acking
  int          cur_wait  = 1;
  int          mcnt      = 0;

  function automatic exp_t ent(input logic [10:0] v);
    exp_t e;
    e.vec = v; e.chk_wd = 1'b0; e.wd = '0; e.chk_din = 1'b0; e.din = '0;
    e.is_done = 1'b0; e.depth_after = 0; e.rdata_after = '0;
    return e;
  endfunction

  function automatic exp_t done_ent(input logic [10:0] flags, input int d, input logic [15:0] r);
    exp_t e;
    e = ent(B_DONE | flags);
    e.is_done = 1'b1;
    e.depth_after = GUARD ? d : 0;
    e.rdata_after = r;
    return e;
  endfunction

  task automatic build(input logic [1:0] code, input logic [15:0] data, input int w);
    exp_t e;
    int   sz;
    sz = vals.size();
    case (code)
      OP_PUSH: begin
        if (GUARD && sz == TB_DMAX) begin
          sched.push_back(done_ent(B_OVF, sz, cur_rdata));
        end else begin
          sched.push_back(ent(B_DEC));
          for (int i = 0; i < w; i++) begin
            e = ent(B_REQ | B_ABUS | B_WE);
            e.chk_wd = 1'b1; e.wd = data;
            sched.push_back(e);
          end
          vals.push_back(data);
          sched.push_back(done_ent('0, sz + 1, cur_rdata));
        end
      end
      OP_POP, OP_PEEK: begin
        if (GUARD && sz == 0) begin
          sched.push_back(done_ent(B_UNF, 0, cur_rdata));
        end else begin
          logic [15:0] top;
          top = (sz > 0) ? vals[sz-1] : 16'h0;
          for (int i = 0; i < w; i++) sched.push_back(ent(B_REQ | B_ABUS));
          if (code == OP_POP) begin
            sched.push_back(ent(B_INC));
            if (sz > 0) vals.pop_back();
            sched.push_back(done_ent('0, vals.size(), top));
          end else begin
            sched.push_back(done_ent('0, sz, top));
          end
        end
      end
      default: begin
        e = ent(B_WRITE);
        e.chk_din = 1'b1; e.din = data;
        sched.push_back(e);
        vals.delete();
        sched.push_back(done_ent('0, 0, cur_rdata));
      end
    endcase
  endtask

  // Per-cycle compare, acceptance tracking and memory responder.
  always @(negedge clk) begin
    exp_t        e;
    logic [10:0] act;
    bit          was_idle;
    if (!rst_n) begin
      sched.delete();
      vals.delete();
      cur_depth = 0;
      cur_rdata = 16'h0;
      mcnt      = 0;
      mem_ack   = 1'b0;
    end else begin
      was_idle = (sched.size() == 0);
      if (was_idle) e = ent(B_READY);
      else          e = sched.pop_front();
      if (e.is_done) begin
        cur_depth = e.depth_after;
        cur_rdata = e.rdata_after;
      end
      act = {op_ready, done, sp_read_abus, sp_read_dbus, sp_write, sp_inc, sp_dec,
             mem_req, mem_we, err_overflow, err_underflow};
      chk("strobes", 32'(act), 32'(e.vec));
      chk("depth", 32'(depth), cur_depth);
      chk("rdata", 32'(rdata), 32'(cur_rdata));
      if (e.chk_wd)  chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
      if (e.chk_din) chk("sp_din", 32'(sp_din), 32'(e.din));
      if (was_idle && op_valid) begin
        cur_wait = plan_wait;
        build(op_code, op_data, plan_wait);
      end
      if (mem_req) begin
        mcnt++;
        mem_ack   = (mcnt >= cur_wait);
        mem_rdata = (mem_ack && !mem_we) ? mem_m[env_sp] : 16'($urandom);
      end else begin
        mcnt      = 0;
        mem_ack   = ($urandom_range(0, 7) == 0); // stray acks must be ignored
        mem_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [1:0] code, input logic [15:0] data, input int w,
                        output int lat, output logic ovf, output logic unf);
    int n;
    plan_wait = w;
    op_code   = code;
    op_data   = data;
    op_valid  = 1'b1;
    lat = 0; ovf = 1'b0; unf = 1'b0;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      chk("accept_timeout", 32'(op_ready), 32'd1);
    end else begin
      lat = 1;
      do begin
        @(negedge clk);
        lat++;
      end while (!done && lat < 64);
      if (!done) chk("done_timeout", 32'(done), 32'd1);
      ovf = err_overflow;
      unf = err_underflow;
    end
    @(posedge clk);
    #1;
  endtask

  int   lat;
  logic ovf, unf;

  initial begin : wd
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst_n = 1'b0;
    #3;
    chk("rst_strobes", 32'({done, sp_read_abus, sp_read_dbus, sp_write, sp_inc, sp_dec,
                           mem_req, mem_we, err_overflow, err_underflow}), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;

    // LOAD_SP 0x1000, PUSH 0xBEEF with zero wait states
    run_op(OP_LOAD, 16'h1000, 1, lat, ovf, unf);
    chk("load_lat", lat, 3);
    run_op(OP_PUSH, 16'hBEEF, 1, lat, ovf, unf);
    chk("push_lat", lat, 4);
    chk("push_mem", 32'(mem_m[16'h0FFE]), 32'hBEEF);
    chk("push_sp", 32'(env_sp), 32'h0FFE);
    chk("push_depth", 32'(depth), GUARD ? 32'd1 : 32'd0);
    chk("model_size", vals.size(), 1);

    // POP with the ack arriving in the third MEM cycle
    run_op(OP_POP, 16'h0, 3, lat, ovf, unf);
    chk("pop_lat", lat, 6);
    chk("pop_rdata", 32'(rdata), 32'hBEEF);
    chk("pop_sp", 32'(env_sp), 32'h1000);
    chk("pop_depth", 32'(depth), 32'd0);

    // PEEK after PUSH 0x1234
    run_op(OP_PUSH, 16'h1234, 1, lat, ovf, unf);
    run_op(OP_PEEK, 16'h0, 2, lat, ovf, unf);
    chk("peek_lat", lat, 4);
    chk("peek_rdata", 32'(rdata), 32'h1234);
    chk("peek_sp", 32'(env_sp), 32'h0FFE);
    chk("peek_depth", 32'(depth), GUARD ? 32'd1 : 32'd0);

`ifdef STACK_SEQ_GUARD_EN
    run_op(OP_LOAD, 16'h2000, 1, lat, ovf, unf);
    run_op(OP_POP, 16'h0, 1, lat, ovf, unf);
    chk("unf_lat", lat, 2);
    chk("unf_flag", 32'({ovf, unf}), 32'd1);
    chk("unf_rdata", 32'(rdata), 32'h1234);
    run_op(OP_PUSH, 16'h0011, 1, lat, ovf, unf);
    run_op(OP_PUSH, 16'h0022, 2, lat, ovf, unf);
    run_op(OP_PUSH, 16'h0033, 1, lat, ovf, unf);
    chk("ovf_lat", lat, 2);
    chk("ovf_flag", 32'({ovf, unf}), 32'd2);
    chk("ovf_depth", 32'(depth), 32'd2);
    chk("ovf_sp", 32'(env_sp), 32'h1FFC);
    run_op(OP_PEEK, 16'h0, 1, lat, ovf, unf);
    chk("peek2_rdata", 32'(rdata), 32'h0022);
`endif

    // reset while a PUSH waits in MEM
    run_op(OP_LOAD, 16'h3000, 1, lat, ovf, unf);
    run_op(OP_PUSH, 16'h0055, 1, lat, ovf, unf);
    plan_wait = 20;
    op_code   = OP_PUSH;
    op_data   = 16'hCAFE;
    op_valid  = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mem_req && n < 20);
    end
    chk("rstmid_in_mem", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_strobes", 32'({done, sp_read_abus, sp_write, sp_inc, sp_dec, mem_req, mem_we}), 32'd0);
    chk("rstmid_depth", 32'(depth), 32'd0);
    chk("rstmid_rdata", 32'(rdata), 32'd0);
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;

    // randomized operations, op_valid mostly held high back to back
    run_op(OP_LOAD, 16'h8000, 1, lat, ovf, unf);
    for (int i = 0; i < 300; i++) begin
      int          r;
      logic [1:0]  c;
      logic [15:0] d;
      r = $urandom_range(0, 99);
      if (r < 10)      c = OP_LOAD;
      else if (r < 50) c = OP_PUSH;
      else if (r < 80) c = OP_POP;
      else             c = OP_PEEK;
      if (!GUARD && (c == OP_POP || c == OP_PEEK) && vals.size() == 0) c = OP_PUSH;
      d = 16'($urandom);
      if (c == OP_LOAD) d[0] = 1'b0;
      run_op(c, d, $urandom_range(1, 4), lat, ovf, unf);
      if ($urandom_range(0, 3) == 0) begin
        op_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    op_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Sequencer for the 16-bit stack pointer register.
- Accepts stack operations from the control unit: PUSH, POP, PEEK, LOAD_SP.
- Drives the SP register's strobes: read_abus, read_dbus, write, inc, dec.
- Runs the memory handshake; data memory addresses come from SP over the address bus.
- Stack is pre-decrement, full-descending, 16-bit words, step 2.

Parameters:
- DATA_W, 16, operand/memory data width.
- DEPTH_MAX, 256, maximum number of words on the stack (guard only).
- OP_W, 2, operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request.
- op_code  in  OP_W  00 PUSH, 01 POP, 10 LOAD_SP, 11 PEEK.
- op_data  in  DATA_W  PUSH value, or new SP value for LOAD_SP.
- op_ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  POP/PEEK result; valid with done, held until the next done.
- sp_din  out  16  value for SP write.
- sp_read_abus  out  1  SP drives address bus.
- sp_read_dbus  out  1  SP drives data bus; never asserted by this block, tied 0.
- sp_write  out  1  SP load strobe.
- sp_inc  out  1  SP += 2.
- sp_dec  out  1  SP -= 2.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  access complete; may be high in the same cycle as mem_req.
- depth  out  $clog2(DEPTH_MAX+1)  words currently on the stack.
- err_overflow  out  1  one-cycle pulse.
- err_underflow  out  1  one-cycle pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; depth=0; rdata=0.
  - All strobes, mem_req, done and err_* are 0; op_ready=1 after release.
  - Reset mid-operation abandons the access with no retry. SP itself is not reset; software issues LOAD_SP first.
- Operation acceptance: on op_valid && op_ready, op_code and op_data are latched and op_ready drops the next cycle. At most one operation is in flight.
- States: IDLE, DEC, MEM, INC, LOAD, DONE.
- PUSH: IDLE -> DEC -> MEM -> DONE.
  - DEC: sp_dec=1 for 1 cycle.
  - MEM: sp_read_abus=1, mem_req=1, mem_we=1, mem_wdata=latched data, held until mem_ack.
  - Minimum 4 cycles from accept to done (no wait states).
- POP: IDLE -> MEM -> INC -> DONE.
  - MEM is a read; rdata is captured on mem_ack.
  - INC: sp_inc=1 for 1 cycle.
- PEEK: IDLE -> MEM -> DONE. Read only; SP and depth unchanged.
- LOAD_SP: IDLE -> LOAD -> DONE.
  - LOAD: sp_write=1 and sp_din=latched data for 1 cycle.
  - depth := 0 (new stack).
- DONE: done=1 for 1 cycle, then IDLE with op_ready=1. Back-to-back operations are accepted the cycle after done.
- Strobe rules:
  - sp_inc, sp_dec and sp_write are mutually exclusive and each lasts exactly 1 cycle.
  - sp_read_abus is high only while mem_req is high.
- Depth: +1 at PUSH done, -1 at POP done; 16-bit SP wrap-around is not detected.
- mem_ack outside MEM is ignored.

Optional Feature:
- Macro: STACK_SEQ_GUARD_EN.
- Defined:
  - PUSH with depth==DEPTH_MAX goes IDLE -> DONE with no SP/memory activity, err_overflow=1 in the DONE cycle, depth unchanged.
  - POP or PEEK with depth==0 does the same with err_underflow=1; rdata is unchanged.
- Undefined:
  - No checks; err_overflow and err_underflow are tied 0.
  - depth is tied 0 and the counter is not synthesised.

Decomposition:
- Package stack_seq_pkg holds:
  - op code constants OP_PUSH, OP_POP, OP_LOAD, OP_PEEK;
  - state enum constants;
  - SP_STEP=2.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- LOAD_SP 0x1000, then PUSH 0xBEEF with mem_ack the same cycle:
  - sp_dec high 1 cycle, then mem_req/mem_we/sp_read_abus for 1 cycle with mem_wdata=0xBEEF.
  - done 4 cycles after accept; depth=1.
- POP with mem_ack delayed 3 cycles, mem_rdata=0xBEEF:
  - mem_req held 3 cycles, then sp_inc for 1 cycle.
  - done with rdata=0xBEEF; depth=0.
- PEEK after PUSH 0x1234: rdata=0x1234; no sp_inc/sp_dec pulse; depth stays 1.
- Guard enabled:
  - POP at depth 0 -> err_underflow pulse, no mem_req, done 2 cycles after accept.
  - DEPTH_MAX=2 with three PUSHes -> third raises err_overflow and depth stays 2.
- rst_n low during a PUSH MEM wait:
  - mem_req, sp_* and done drop immediately (asynchronously); depth=0.
  - op_ready=1 after release.
- op_valid held high continuously with 4 queued ops: each is accepted only in IDLE, and strobes never overlap.
